// File: rtl/shift_reg_engine.sv
// WIDTH-bit storage register with parallel load, clear and multi-step shift/rotate
// commands executed one bit per clock behind a start/busy/done handshake.
module shift_reg_engine #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       mode,
   input  logic [AMT_W-1:0] amt,
   input  logic [WIDTH-1:0] D,
   input  logic             sin,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Qb,
   output logic             sout,
   output logic             busy,
   output logic             done
);

   localparam logic [2:0] MODE_NOP   = 3'b000;
   localparam logic [2:0] MODE_LOAD  = 3'b001;
   localparam logic [2:0] MODE_SHL   = 3'b010;
   localparam logic [2:0] MODE_SHR   = 3'b011;
   localparam logic [2:0] MODE_ROL   = 3'b100;
   localparam logic [2:0] MODE_ROR   = 3'b101;
   localparam logic [2:0] MODE_ASR   = 3'b110;
   localparam logic [2:0] MODE_CLEAR = 3'b111;

   localparam logic [AMT_W-1:0] CNT_ONE = AMT_W'(1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] reg_q, reg_d;
   logic [AMT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       modeLatched_q, modeLatched_d;
   logic             sout_q, sout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   // busy/done come straight from flops so they never glitch on a state decode.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         reg_q         <= '0;
         cnt_q         <= '0;
         modeLatched_q <= MODE_NOP;
         sout_q        <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         reg_q         <= reg_d;
         cnt_q         <= cnt_d;
         modeLatched_q <= modeLatched_d;
         sout_q        <= sout_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      reg_d         = reg_q;
      cnt_d         = cnt_q;
      modeLatched_d = modeLatched_q;
      sout_d        = sout_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = DONE;
               case (mode)
                  MODE_NOP:   reg_d = reg_q;
                  MODE_LOAD:  reg_d = D;
                  MODE_CLEAR: reg_d = '0;
                  default: begin
                     if (amt != '0) begin
                        modeLatched_d = mode;
                        cnt_d         = amt;
                        state_d       = SHIFT;
                     end
                  end
               endcase
            end
         end
         SHIFT: begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               state_d = DONE;
            end
            case (modeLatched_q)
               MODE_SHL: begin
                  reg_d  = {reg_q[WIDTH-2:0], sin};
                  sout_d = reg_q[WIDTH-1];
               end
               MODE_SHR: begin
                  reg_d  = {sin, reg_q[WIDTH-1:1]};
                  sout_d = reg_q[0];
               end
               MODE_ROL: begin
                  reg_d  = {reg_q[WIDTH-2:0], reg_q[WIDTH-1]};
                  sout_d = reg_q[WIDTH-1];
               end
               MODE_ROR: begin
                  reg_d  = {reg_q[0], reg_q[WIDTH-1:1]};
                  sout_d = reg_q[0];
               end
               MODE_ASR: begin
                  reg_d  = {reg_q[WIDTH-1], reg_q[WIDTH-1:1]};
                  sout_d = reg_q[0];
               end
               default: begin
                  reg_d  = reg_q;
                  sout_d = sout_q;
               end
            endcase
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d == SHIFT);
      done_d = (state_d == DONE);
   end

   assign Q    = reg_q;
   assign Qb   = ~reg_q;
   assign sout = sout_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule
